// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared PCS constants, lock FSM states and sync header helper
// Used by the 64b/66b block-lock controller and its neighbours.
package pcs_pkg;

   localparam int HEAD_W = 2;
   localparam logic [HEAD_W-1:0] SYNC_HEAD_DATA = 2'b01;
   localparam logic [HEAD_W-1:0] SYNC_HEAD_CTRL = 2'b10;

   localparam int DEF_SH_CNT_MAX = 64;
   localparam int DEF_SH_INV_MAX = 16;
   localparam int DEF_SLIP_WAIT  = 2;

   typedef enum logic [1:0] {
      UNLOCK = 2'd0,
      LOCK   = 2'd1,
      SLIP_W = 2'd2
   } lock_state_e;

   function automatic logic sync_head_ok(input logic [HEAD_W-1:0] head);
      return (head == SYNC_HEAD_DATA) || (head == SYNC_HEAD_CTRL);
   endfunction

endpackage

// File: rtl/pcs_block_lock.sv
// rtl/pcs_block_lock.sv - 64b/66b block-lock FSM driving gearbox bit slip
// Hunts for sync header alignment with slip pulses, then monitors header error rate.
module pcs_block_lock
   import pcs_pkg::*;
#(
   parameter int SH_CNT_MAX = DEF_SH_CNT_MAX,
   parameter int SH_INV_MAX = DEF_SH_INV_MAX,
   parameter int SLIP_WAIT  = DEF_SLIP_WAIT
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              signal_ok_i,
   input  logic              valid_i,
   input  logic [HEAD_W-1:0] head_i,
   output logic              slip_v_o,
   output logic              lock_v_o
);

   localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
   localparam int INV_W  = $clog2(SH_INV_MAX + 1);
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

   lock_state_e       state, state_nxt;
   logic [SH_W-1:0]   sh_cnt, sh_nxt, sh_inc;
   logic [INV_W-1:0]  inv_cnt, inv_nxt, inv_inc;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              lock_nxt, slip_nxt;
   logic              sample, hdr_ok;

   assign hdr_ok  = sync_head_ok(head_i);
   assign sample  = valid_i & signal_ok_i & (state != SLIP_W);
   assign sh_inc  = sh_cnt + 1'b1;
   assign inv_inc = inv_cnt + {{(INV_W-1){1'b0}}, ~hdr_ok};

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= UNLOCK;
         sh_cnt   <= '0;
         inv_cnt  <= '0;
         wait_cnt <= '0;
         lock_v_o <= 1'b0;
         slip_v_o <= 1'b0;
      end else begin
         state    <= state_nxt;
         sh_cnt   <= sh_nxt;
         inv_cnt  <= inv_nxt;
         wait_cnt <= wait_nxt;
         lock_v_o <= lock_nxt;
         slip_v_o <= slip_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sh_nxt    = sh_cnt;
      inv_nxt   = inv_cnt;
      wait_nxt  = wait_cnt;
      lock_nxt  = lock_v_o;
      slip_nxt  = 1'b0;
      if (!signal_ok_i) begin
         state_nxt = UNLOCK;
         sh_nxt    = '0;
         inv_nxt   = '0;
         wait_nxt  = '0;
         lock_nxt  = 1'b0;
      end else begin
         case (state)
            UNLOCK: begin
               lock_nxt = 1'b0;
               if (sample) begin
                  // Any bad header while hunting means the alignment is wrong: slip at once.
                  if (!hdr_ok) begin
                     slip_nxt  = 1'b1;
                     sh_nxt    = '0;
                     inv_nxt   = '0;
                     wait_nxt  = '0;
                     state_nxt = SLIP_W;
                  end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                     lock_nxt  = 1'b1;
                     sh_nxt    = '0;
                     inv_nxt   = '0;
                     state_nxt = LOCK;
                  end else begin
                     sh_nxt = sh_inc;
                  end
               end
            end
            LOCK: begin
               if (sample) begin
                  // Checked before window end so a window closing on its last bad header unlocks.
                  if (inv_inc == INV_W'(SH_INV_MAX)) begin
                     lock_nxt  = 1'b0;
                     slip_nxt  = 1'b1;
                     sh_nxt    = '0;
                     inv_nxt   = '0;
                     wait_nxt  = '0;
                     state_nxt = SLIP_W;
                  end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                     sh_nxt  = '0;
                     inv_nxt = '0;
                  end else begin
                     sh_nxt  = sh_inc;
                     inv_nxt = inv_inc;
                  end
               end
            end
            SLIP_W: begin
               lock_nxt = 1'b0;
               if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                  wait_nxt  = '0;
                  state_nxt = UNLOCK;
               end else begin
                  wait_nxt = wait_cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = UNLOCK;
               sh_nxt    = '0;
               inv_nxt   = '0;
               wait_nxt  = '0;
               lock_nxt  = 1'b0;
            end
         endcase
      end
   end

endmodule
